// File: rtl/nthband_pkg.sv
// Shared types and width helpers for the n-th band predictor.
// Lane datapath widths are derived here so the top and lanes agree.
package nthband_pkg;

    typedef enum logic {
        S_PARAMS = 1'b0,
        S_STREAM = 1'b1
    } state_e;

    // Signed difference of two unsigned samples needs one extra bit.
    function automatic int diff_width(input int data_width);
        return data_width + 1;
    endfunction

    // Signed difference times sign-extended unsigned alpha.
    function automatic int prod_width(input int data_width, input int alpha_width);
        return data_width + alpha_width + 2;
    endfunction

endpackage

// File: rtl/nthband_lane.sv
// One lane of the predictor: difference, multiply, then round/add/clamp.
// Block parameters ride along with the sample so each beat uses its own block's values.
module nthband_lane
    import nthband_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ALPHA_WIDTH = 10,
    parameter int ALPHA_FRAC  = ALPHA_WIDTH - 1
) (
    input  logic                   clk,
    input  logic                   en_i,
    input  logic [DATA_WIDTH-1:0]  xhat_i,
    input  logic [DATA_WIDTH-1:0]  xhatmean_i,
    input  logic [DATA_WIDTH-1:0]  xmean_i,
    input  logic [ALPHA_WIDTH-1:0] alpha_i,
    input  logic                   first_i,
    output logic [DATA_WIDTH-1:0]  pred_o
);

    localparam int DIFF_W = diff_width(DATA_WIDTH);
    localparam int PROD_W = prod_width(DATA_WIDTH, ALPHA_WIDTH);
    localparam int SUM_W  = PROD_W + 1;
    localparam logic signed [PROD_W-1:0] HALF     = PROD_W'(2 ** (ALPHA_FRAC - 1));
    localparam logic signed [SUM_W-1:0]  PRED_MAX = {{(SUM_W-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    logic signed [DIFF_W-1:0]  diff_q;
    logic [ALPHA_WIDTH-1:0]    alpha1_q;
    logic [DATA_WIDTH-1:0]     xmean1_q, xmean2_q;
    logic                      first1_q, first2_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic [DATA_WIDTH-1:0]     pred_q, pred_d;

    logic signed [PROD_W-1:0]  rounded;
    logic signed [PROD_W-1:0]  shifted;
    logic signed [SUM_W-1:0]   sum;

    // NOTE: datapath registers carry no reset; the stage valids in the top decide whether their contents matter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every stage samples the previous stage's old value.
        if (en_i) begin
            diff_q   <= $signed({1'b0, xhat_i}) - $signed({1'b0, xhatmean_i});
            alpha1_q <= alpha_i;
            xmean1_q <= xmean_i;
            first1_q <= first_i;

            prod_q   <= PROD_W'(diff_q) * PROD_W'($signed({1'b0, alpha1_q}));
            xmean2_q <= xmean1_q;
            first2_q <= first1_q;

            pred_q   <= pred_d;
        end
    end

    always_comb begin
        rounded = prod_q + HALF;
        shifted = rounded >>> ALPHA_FRAC;
        sum     = SUM_W'(shifted) + SUM_W'($signed({1'b0, xmean2_q}));
        if (first2_q) begin
            pred_d = xmean2_q;
        end else if (sum[SUM_W-1]) begin
            pred_d = '0;
        end else if (sum > PRED_MAX) begin
            pred_d = '1;
        end else begin
            pred_d = sum[DATA_WIDTH-1:0];
        end
    end

    assign pred_o = pred_q;

endmodule

// File: rtl/nthband_predictor_multilane.sv
// Multi-lane n-th band predictor: joint per-block parameter handshake, then a block of
// reference beats streamed through LANES identical 3-stage lanes sharing one stall enable.
module nthband_predictor_multilane
    import nthband_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ALPHA_WIDTH    = 10,
    parameter int ALPHA_FRAC     = ALPHA_WIDTH - 1,
    parameter int BLOCK_SIZE_LOG = 8,
    parameter int LANES          = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alpha_valid_i,
    output logic                          alpha_ready_o,
    input  logic [ALPHA_WIDTH-1:0]        alpha_data_i,
    input  logic                          alpha_first_band_i,
    input  logic                          xmean_valid_i,
    output logic                          xmean_ready_o,
    input  logic [DATA_WIDTH-1:0]         xmean_data_i,
    input  logic                          xhatmean_valid_i,
    output logic                          xhatmean_ready_o,
    input  logic [DATA_WIDTH-1:0]         xhatmean_data_i,
    input  logic                          xhat_valid_i,
    output logic                          xhat_ready_o,
    input  logic [LANES*DATA_WIDTH-1:0]   xhat_data_i,
    output logic                          prediction_valid_o,
    input  logic                          prediction_ready_i,
    output logic [LANES*DATA_WIDTH-1:0]   prediction_data_o,
    output logic                          prediction_last_o
);

    localparam int LANES_LOG = $clog2(LANES);
    localparam int BEAT_W    = (BLOCK_SIZE_LOG > LANES_LOG) ? BLOCK_SIZE_LOG - LANES_LOG : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 ** (BLOCK_SIZE_LOG - LANES_LOG) - 1);

    state_e                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [ALPHA_WIDTH-1:0] alpha_q;
    logic [DATA_WIDTH-1:0] xmean_q, xhatmean_q;
    logic                  first_q;
    logic                  v1_q, v2_q, v3_q;
    logic                  l1_q, l2_q, l3_q;

    logic params_all, params_ready, xhat_ready, xhat_fire, pipe_en;

    assign params_all = alpha_valid_i & xmean_valid_i & xhatmean_valid_i;
    assign pipe_en    = !v3_q | prediction_ready_i;
    assign xhat_fire  = xhat_ready & xhat_valid_i;

    // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        params_ready = 1'b0;
        xhat_ready   = 1'b0;
        unique case (state_q)
            S_PARAMS: begin
                params_ready = params_all;
                if (params_all) state_d = S_STREAM;
            end
            S_STREAM: begin
                xhat_ready = pipe_en;
                if (xhat_valid_i && pipe_en) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_PARAMS;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
        endcase
        if (rst) begin
            params_ready = 1'b0;
            xhat_ready   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PARAMS;
            beat_q  <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            l1_q    <= 1'b0;
            l2_q    <= 1'b0;
            l3_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (pipe_en) begin
                v1_q <= xhat_fire;
                l1_q <= xhat_fire && (beat_q == LAST_BEAT);
                v2_q <= v1_q;
                l2_q <= l1_q;
                v3_q <= v2_q;
                l3_q <= l2_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (params_ready) begin
            alpha_q    <= alpha_data_i;
            xmean_q    <= xmean_data_i;
            xhatmean_q <= xhatmean_data_i;
            first_q    <= alpha_first_band_i;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        nthband_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ALPHA_WIDTH(ALPHA_WIDTH),
            .ALPHA_FRAC (ALPHA_FRAC)
        ) u_lane (
            .clk       (clk),
            .en_i      (pipe_en),
            .xhat_i    (xhat_data_i[g*DATA_WIDTH +: DATA_WIDTH]),
            .xhatmean_i(xhatmean_q),
            .xmean_i   (xmean_q),
            .alpha_i   (alpha_q),
            .first_i   (first_q),
            .pred_o    (prediction_data_o[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign alpha_ready_o      = params_ready;
    assign xmean_ready_o      = params_ready;
    assign xhatmean_ready_o   = params_ready;
    assign xhat_ready_o       = xhat_ready;
    assign prediction_valid_o = v3_q;
    assign prediction_last_o  = l3_q;

endmodule

// File: tb/tb_nthband_predictor_multilane.sv
// Scoreboard bench: the driver pushes expected beats from an arithmetic reference model,
// a negedge monitor pops and compares whenever a prediction beat is transferred.
module tb_nthband_predictor_multilane;

    localparam int DW    = 16;
    localparam int AW    = 10;
    localparam int AF    = 9;
    localparam int BSL   = 8;
    localparam int L     = 4;
    localparam int BEATS = (1 << BSL) / L;

    typedef struct packed {
        logic [AW-1:0]       alpha;
        logic [DW-1:0]       xmean;
        logic [DW-1:0]       xhatmean;
        logic                first;
        logic                fixed;
        logic [L-1:0][DW-1:0] fx;
    } blk_t;

    typedef struct packed {
        logic [L*DW-1:0] data;
        logic            last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            alpha_valid, alpha_ready, alpha_first_band;
    logic [AW-1:0]   alpha_data;
    logic            xmean_valid, xmean_ready;
    logic [DW-1:0]   xmean_data;
    logic            xhatmean_valid, xhatmean_ready;
    logic [DW-1:0]   xhatmean_data;
    logic            xhat_valid, xhat_ready;
    logic [L*DW-1:0] xhat_data;
    logic            prediction_valid, prediction_ready, prediction_last;
    logic [L*DW-1:0] prediction_data;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   ready_mode = 1'b0;
    blk_t blks[11];

    nthband_predictor_multilane #(
        .DATA_WIDTH(DW), .ALPHA_WIDTH(AW), .ALPHA_FRAC(AF), .BLOCK_SIZE_LOG(BSL), .LANES(L)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .alpha_valid_i     (alpha_valid),
        .alpha_ready_o     (alpha_ready),
        .alpha_data_i      (alpha_data),
        .alpha_first_band_i(alpha_first_band),
        .xmean_valid_i     (xmean_valid),
        .xmean_ready_o     (xmean_ready),
        .xmean_data_i      (xmean_data),
        .xhatmean_valid_i  (xhatmean_valid),
        .xhatmean_ready_o  (xhatmean_ready),
        .xhatmean_data_i   (xhatmean_data),
        .xhat_valid_i      (xhat_valid),
        .xhat_ready_o      (xhat_ready),
        .xhat_data_i       (xhat_data),
        .prediction_valid_o(prediction_valid),
        .prediction_ready_i(prediction_ready),
        .prediction_data_o (prediction_data),
        .prediction_last_o (prediction_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: floor-rounded fixed-point scaling of the deviation, then clamp.
    function automatic int ref_pred(input int alpha, input int xmean, input int xhatmean,
                                    input int xhat, input bit first);
        longint p, t, q, r;
        if (first) return xmean;
        p = longint'(alpha) * longint'(xhat - xhatmean);
        t = p + (64'sd1 << (AF - 1));
        q = t / (64'sd1 << AF);
        if (t < 0 && (t % (64'sd1 << AF)) != 0) q = q - 1;
        r = longint'(xmean) + q;
        if (r < 0) r = 0;
        if (r > 65535) r = 65535;
        return int'(r);
    endfunction

    function automatic blk_t mk(input int a, input int xm, input int xhm, input bit first,
                                input bit fixed, input int f0, input int f1, input int f2, input int f3);
        blk_t b;
        b.alpha    = AW'(a);
        b.xmean    = DW'(xm);
        b.xhatmean = DW'(xhm);
        b.first    = first;
        b.fixed    = fixed;
        b.fx[0]    = DW'(f0);
        b.fx[1]    = DW'(f1);
        b.fx[2]    = DW'(f2);
        b.fx[3]    = DW'(f3);
        return b;
    endfunction

    // Output consumer: always ready or 50% random.
    initial begin
        prediction_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            prediction_ready = ready_mode ? 1'($urandom % 2) : 1'b1;
        end
    end

    // Monitor.
    logic [L*DW-1:0] hold_data;
    logic            hold_last;
    bit              hold_pending = 1'b0;
    bit              param_seen   = 1'b0;
    int              xhat_cnt     = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
            hold_pending = 1'b0;
            param_seen   = 1'b0;
            xhat_cnt     = 0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 64'(prediction_valid), 64'd1);
                check("hold_data", 64'(prediction_data), 64'(hold_data));
                check("hold_last", 64'(prediction_last), 64'(hold_last));
            end
            hold_pending = prediction_valid && !prediction_ready;
            hold_data    = prediction_data;
            hold_last    = prediction_last;
            if (prediction_valid && prediction_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("pred_data", 64'(prediction_data), 64'(e.data));
                    check("pred_last", 64'(prediction_last), 64'(e.last));
                end
            end
            if (xhat_valid && xhat_ready) xhat_cnt++;
            if (alpha_valid && alpha_ready) begin
                check("joint_ready", {61'd0, alpha_ready, xmean_ready, xhatmean_ready}, 64'd7);
                if (param_seen) check("params_after_block", 64'(xhat_cnt), 64'(BEATS));
                param_seen = 1'b1;
                xhat_cnt   = 0;
            end
            if (xhat_ready || alpha_ready) check("ready_exclusive", 64'(xhat_ready && alpha_ready), 64'd0);
        end
    end

    task automatic present_params(input blk_t b);
        alpha_valid      = 1'b1;
        xmean_valid      = 1'b1;
        xhatmean_valid   = 1'b1;
        alpha_data       = b.alpha;
        alpha_first_band = b.first;
        xmean_data       = b.xmean;
        xhatmean_data    = b.xhatmean;
    endtask

    task automatic drop_params();
        alpha_valid    = 1'b0;
        xmean_valid    = 1'b0;
        xhatmean_valid = 1'b0;
    endtask

    task automatic wait_params();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (alpha_valid && alpha_ready) begin
                @(posedge clk);
                #1;
                drop_params();
                return;
            end
        end
        check("param_timeout", 64'd0, 64'd1);
    endtask

    task automatic stream(input blk_t b, input int rst_at, input bit measure);
        exp_t e;
        bit   fired;
        int   x, n;
        for (int beat = 0; beat < BEATS; beat++) begin
            if (beat == rst_at) return;
            if (!b.fixed && ($urandom % 4) == 0) begin
                xhat_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            for (int ln = 0; ln < L; ln++) begin
                x = b.fixed ? int'(b.fx[ln]) : int'($urandom % 65536);
                xhat_data[ln*DW +: DW] = DW'(x);
                e.data[ln*DW +: DW] = DW'(ref_pred(int'(b.alpha), int'(b.xmean), int'(b.xhatmean), x, b.first));
            end
            e.last     = (beat == BEATS - 1);
            xhat_valid = 1'b1;
            fired      = 1'b0;
            for (int i = 0; i < 300 && !fired; i++) begin
                @(negedge clk);
                if (xhat_ready) begin
                    sb_q.push_back(e);
                    fired = 1'b1;
                end
            end
            if (!fired) begin
                check("xhat_timeout", 64'd0, 64'd1);
                xhat_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            xhat_valid = 1'b0;
            if (measure && beat == 0) begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!prediction_valid && n < 10);
                check("latency", 64'(n), 64'd3);
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        alpha_valid = 1'b1; xmean_valid = 1'b1; xhatmean_valid = 1'b1; xhat_valid = 1'b1;
        alpha_data = '0; alpha_first_band = 1'b0; xmean_data = '0; xhatmean_data = '0; xhat_data = '0;

        blks[0]  = mk(512, 640, 384, 1'b0, 1'b1, 256, 256, 256, 256);
        blks[1]  = mk(256, 640, 384, 1'b0, 1'b1, 256, 256, 256, 256);
        blks[2]  = mk(256, 1000, 100, 1'b0, 1'b1, 101, 99, 100, 102);
        blks[3]  = mk(512, 0, 1000, 1'b0, 1'b1, 0, 0, 0, 0);
        blks[4]  = mk(1023, 65000, 0, 1'b0, 1'b1, 2000, 2000, 2000, 2000);
        blks[5]  = mk(int'($urandom % 1024), 1234, int'($urandom % 65536), 1'b1, 1'b0, 0, 0, 0, 0);
        for (int i = 6; i < 11; i++)
            blks[i] = mk(int'($urandom % 1024), int'($urandom % 65536), int'($urandom % 65536),
                         1'b0, 1'b0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(prediction_valid), 64'd0);
        check("rst_last", 64'(prediction_last), 64'd0);
        check("rst_readys", {60'd0, alpha_ready, xmean_ready, xhatmean_ready, xhat_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        xhat_valid = 1'b0;
        drop_params();

        present_params(blks[0]);
        wait_params();
        for (int b = 0; b < 9; b++) begin
            if (b == 6) ready_mode = 1'b1;
            present_params(blks[b+1]);
            stream(blks[b], -1, b == 0);
            wait_params();
        end

        // Mid-block reset after 20 accepted beats of block 9.
        stream(blks[9], 20, 1'b0);
        xhat_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_readys", {60'd0, alpha_ready, xmean_ready, xhatmean_ready, xhat_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid_drop", 64'(prediction_valid), 64'd0);
        check("rst_xhat_blocked", 64'(xhat_ready), 64'd0);
        @(posedge clk);
        #1;
        xhat_valid = 1'b0;

        present_params(blks[10]);
        wait_params();
        stream(blks[10], -1, 1'b0);

        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
